// File: rtl/tx_bus_frame.sv
// Transmit frame builder: writes a 7-byte header and payload from source memory into the tx buffer, then starts the link.
// Latency: tx_start is asserted 8+tx_len cycles after an accepted tx_req; tx_err is asserted one cycle after a rejected request.
// Backpressure: no queueing; tx_req is dropped while busy. Optional WAIT timeout is enabled by the TX_BUS_TIMEOUT_EN macro.
module tx_bus_frame #(
    parameter int BUF_AW      = 11,
    parameter int HDR_LEN     = 7,
    parameter int MAX_PAYLOAD = 2039,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ini_done,
    input  logic              tx_req,
    input  logic [7:0]        tx_da,
    input  logic [7:0]        tx_fc,
    input  logic [7:0]        tx_mode,
    input  logic [23:0]       tx_addr,
    input  logic [BUF_AW-1:0] tx_len,
    input  logic [2:0]        rack_id,
    input  logic [3:0]        slot_id,
    output logic              src_rden,
    output logic [23:0]       src_raddr,
    input  logic [7:0]        src_rdata,
    output logic              tx_buf_wren,
    output logic [BUF_AW-1:0] tx_buf_waddr,
    output logic [7:0]        tx_buf_wdata,
    output logic              tx_start,
    output logic [BUF_AW-1:0] tx_frame_len,
    input  logic              tx_done,
    output logic              busy,
    output logic              tx_err,
    output logic              tx_timeout
);

    localparam logic [BUF_AW-1:0] MAX_PAY_L = BUF_AW'(MAX_PAYLOAD);
    localparam logic [BUF_AW-1:0] HDR_LEN_L = BUF_AW'(HDR_LEN);
    localparam logic [2:0]        HDR_LAST  = 3'(HDR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_START,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;

    // Frame fields captured at accept; later changes on the inputs are ignored.
    logic [7:0]        da_q, sa_q, fc_q, mode_q;
    logic [23:0]       addr_q;
    logic [BUF_AW-1:0] len_q;

    logic [2:0]        hdr_cnt_q;    // header byte index
    logic [BUF_AW-1:0] wr_idx_q;     // payload byte being written this cycle
    logic [23:0]       rd_addr_q;    // next source read address, wraps at 24 bits
    logic [BUF_AW-1:0] frame_len_q;
    logic              err_q;

    logic              req_ok;
    logic              accept;
    logic              reject;
    logic [7:0]        hdr_byte;
    logic              rden_c;
    logic              timeout_c;

    assign req_ok = (state_q == S_IDLE) && tx_req && ini_done;
    assign accept = req_ok && (tx_len <= MAX_PAY_L);
    assign reject = req_ok && (tx_len >  MAX_PAY_L);

`ifdef TX_BUS_TIMEOUT_EN
    localparam int         CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_cnt_q;

    // Count cycles spent in WAIT; the first WAIT cycle is the one after tx_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Expiry fires only if tx_done is absent that cycle; a coincident tx_done wins.
    assign timeout_c = (state_q == S_WAIT) && !tx_done && (wait_cnt_q == TO_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    // Header byte mux in wire order: DA, SA, FC, MODE, ADDR hi, mid, lo.
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_cnt_q)
            3'd0:    hdr_byte = da_q;
            3'd1:    hdr_byte = sa_q;
            3'd2:    hdr_byte = fc_q;
            3'd3:    hdr_byte = mode_q;
            3'd4:    hdr_byte = addr_q[23:16];
            3'd5:    hdr_byte = addr_q[15:8];
            3'd6:    hdr_byte = addr_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next-state and per-cycle strobes for the frame builder.
    always_comb begin
        state_d      = state_q;
        rden_c       = 1'b0;
        tx_buf_wren  = 1'b0;
        tx_buf_waddr = '0;
        tx_buf_wdata = 8'h00;
        tx_start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                tx_buf_wren  = 1'b1;
                tx_buf_waddr = BUF_AW'(hdr_cnt_q);
                tx_buf_wdata = hdr_byte;
                if (hdr_cnt_q == HDR_LAST) begin
                    if (len_q != '0) begin
                        // Issue the first payload read so its data lands in the first PAY cycle.
                        rden_c  = 1'b1;
                        state_d = S_PAY;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_PAY: begin
                tx_buf_wren  = 1'b1;
                tx_buf_waddr = HDR_LEN_L + wr_idx_q;
                tx_buf_wdata = src_rdata;
                if ((wr_idx_q + 1'b1) < len_q) begin
                    rden_c = 1'b1;
                end
                if (wr_idx_q == (len_q - 1'b1)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done || timeout_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, field capture and address/index counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            da_q        <= 8'h00;
            sa_q        <= 8'h00;
            fc_q        <= 8'h00;
            mode_q      <= 8'h00;
            addr_q      <= 24'h0;
            len_q       <= '0;
            hdr_cnt_q   <= 3'd0;
            wr_idx_q    <= '0;
            rd_addr_q   <= 24'h0;
            frame_len_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (accept) begin
                da_q   <= tx_da;
                sa_q   <= {1'b0, rack_id, slot_id};
                fc_q   <= tx_fc;
                mode_q <= tx_mode;
                addr_q <= tx_addr;
                len_q  <= tx_len;
            end
            hdr_cnt_q <= (state_q == S_HDR) ? hdr_cnt_q + 1'b1 : 3'd0;
            wr_idx_q  <= (state_q == S_PAY) ? wr_idx_q + 1'b1 : '0;
            if (accept) begin
                rd_addr_q <= tx_addr;
            end else if (rden_c) begin
                rd_addr_q <= rd_addr_q + 24'h1;
            end
            // Frame length is published on entry to START and held until the next frame reaches START.
            if ((state_d == S_START) && (state_q != S_START)) begin
                frame_len_q <= HDR_LEN_L + len_q;
            end
        end
    end

    assign src_rden     = rden_c;
    assign src_raddr    = rden_c ? rd_addr_q : 24'h0;
    assign tx_frame_len = frame_len_q;
    assign busy         = (state_q != S_IDLE);
    assign tx_err       = err_q;
    assign tx_timeout   = timeout_c;

endmodule

// File: tb/tb_tx_bus_frame.sv
module tb_tx_bus_frame;

`ifdef TX_BUS_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65535;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ini_done = 1'b0;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_da = 8'h00, tx_fc = 8'h00, tx_mode = 8'h00;
    logic [23:0] tx_addr = 24'h0;
    logic [10:0] tx_len = 11'd0;
    logic [2:0]  rack_id = 3'd2;
    logic [3:0]  slot_id = 4'd5;
    logic        src_rden;
    logic [23:0] src_raddr;
    logic [7:0]  src_rdata = 8'h00;
    logic        tx_buf_wren;
    logic [10:0] tx_buf_waddr;
    logic [7:0]  tx_buf_wdata;
    logic        tx_start;
    logic [10:0] tx_frame_len;
    logic        tx_done = 1'b0;
    logic        busy, tx_err, tx_timeout;

    tx_bus_frame #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ini_done(ini_done), .tx_req(tx_req),
        .tx_da(tx_da), .tx_fc(tx_fc), .tx_mode(tx_mode), .tx_addr(tx_addr),
        .tx_len(tx_len), .rack_id(rack_id), .slot_id(slot_id),
        .src_rden(src_rden), .src_raddr(src_raddr), .src_rdata(src_rdata),
        .tx_buf_wren(tx_buf_wren), .tx_buf_waddr(tx_buf_waddr), .tx_buf_wdata(tx_buf_wdata),
        .tx_start(tx_start), .tx_frame_len(tx_frame_len), .tx_done(tx_done),
        .busy(busy), .tx_err(tx_err), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory: one-cycle read latency, data = low address byte ^ 0xA5.
    always @(posedge clk) src_rdata <= src_rden ? (src_raddr[7:0] ^ 8'hA5) : 8'h00;

    // Observers sampled mid-cycle.
    logic [7:0]  tbuf [0:2047];
    logic [23:0] rd_log [0:8191];
    int wr_cnt = 0, rd_cnt = 0, start_cnt = 0, err_cnt = 0, to_cnt = 0;
    int start_cyc = 0, err_cyc = 0, to_cyc = 0, last_waddr = 0;
    int fl_at_start = 0;
    always @(negedge clk) begin
        if (tx_buf_wren) begin
            tbuf[tx_buf_waddr] <= tx_buf_wdata;
            wr_cnt <= wr_cnt + 1;
            last_waddr <= int'(tx_buf_waddr);
        end
        if (src_rden) begin
            rd_log[rd_cnt % 8192] <= src_raddr;
            rd_cnt <= rd_cnt + 1;
        end
        if (tx_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            fl_at_start <= int'(tx_frame_len);
        end
        if (tx_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    int req_cyc = 0;
    int b_wr, b_rd, b_st, b_err, b_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        step(1);
        b_wr = wr_cnt; b_rd = rd_cnt; b_st = start_cnt; b_err = err_cnt; b_to = to_cnt;
    endtask

    task automatic send(input logic [7:0] da, input logic [7:0] fc, input logic [7:0] md,
                        input logic [23:0] ad, input logic [10:0] ln);
        tx_da = da; tx_fc = fc; tx_mode = md; tx_addr = ad; tx_len = ln; tx_req = 1'b1;
        req_cyc = cyc;
        step(1);
        tx_req = 1'b0;
        tx_da = 8'hEE; tx_fc = 8'hEE; tx_mode = 8'hEE; tx_addr = 24'hEEEEEE; tx_len = 11'd1;
    endtask

    task automatic wait_start(input string tag, input int budget);
        for (int i = 0; i < budget && start_cnt == b_st; i++) step(1);
        step(1);
        chk(tag, 32'(start_cnt - b_st), 32'd1);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        step(1);
    endtask

    localparam logic [7:0] EXP_A [0:10] = '{8'h12, 8'h25, 8'h03, 8'h40, 8'h00, 8'h01, 8'h00,
                                            8'hA5, 8'hA4, 8'hA7, 8'hA6};

    initial begin
        // Reset state
        step(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({src_rden, tx_buf_wren, tx_start, tx_err, tx_timeout}), 0);
        chk("rst_flen", 32'(tx_frame_len), 0);
        chk("rst_raddr", 32'(src_raddr), 0);
        reset = 1'b0;
        step(2);

        // Request while not initialised is ignored
        snap();
        send(8'h12, 8'h03, 8'h40, 24'h000100, 11'd4);
        step(3);
        chk("noini_busy", 32'(busy), 0);
        chk("noini_wr", 32'(wr_cnt - b_wr), 0);
        ini_done = 1'b1;

        // Basic frame, len=4
        snap();
        send(8'h12, 8'h03, 8'h40, 24'h000100, 11'd4);
        wait_start("a_start", 40);
        chk("a_lat", 32'(start_cyc - req_cyc), 12);
        chk("a_flen", 32'(fl_at_start), 11);
        chk("a_wr", 32'(wr_cnt - b_wr), 11);
        chk("a_rd", 32'(rd_cnt - b_rd), 4);
        for (int i = 0; i < 11; i++) chk($sformatf("a_buf%0d", i), 32'(tbuf[i]), 32'(EXP_A[i]));
        chk("a_busy_wait", 32'(busy), 1);
        step(20);
`ifdef TX_BUS_TIMEOUT_EN
        chk("a_to_fire", 32'(to_cnt - b_to), 1);
        chk("a_to_lat", 32'(to_cyc - start_cyc), 16);
        chk("a_to_busy", 32'(busy), 0);
`else
        chk("a_no_to", 32'(to_cnt - b_to), 0);
        chk("a_hold", 32'(busy), 1);
        done_pulse();
        chk("a_idle", 32'(busy), 0);
`endif

        // Zero-length frame
        snap();
        send(8'hAB, 8'h01, 8'h02, 24'h000300, 11'd0);
        wait_start("z_start", 20);
        chk("z_lat", 32'(start_cyc - req_cyc), 8);
        chk("z_flen", 32'(fl_at_start), 7);
        chk("z_wr", 32'(wr_cnt - b_wr), 7);
        chk("z_rd", 32'(rd_cnt - b_rd), 0);
        chk("z_da", 32'(tbuf[0]), 32'hAB);
        done_pulse();
        chk("z_idle", 32'(busy), 0);

        // Oversize request rejected
        snap();
        send(8'h11, 8'h22, 8'h33, 24'h0, 11'd2040);
        step(4);
        chk("e_err", 32'(err_cnt - b_err), 1);
        chk("e_errlat", 32'(err_cyc - req_cyc), 1);
        chk("e_wr", 32'(wr_cnt - b_wr), 0);
        chk("e_busy", 32'(busy), 0);

        // Maximum payload
        snap();
        send(8'h01, 8'h02, 8'h03, 24'h000000, 11'd2039);
        wait_start("m_start", 2100);
        chk("m_lat", 32'(start_cyc - req_cyc), 2047);
        chk("m_last", 32'(last_waddr), 2045);
        chk("m_wr", 32'(wr_cnt - b_wr), 2046);
        chk("m_flen", 32'(fl_at_start), 2046);
        chk("m_err", 32'(err_cnt - b_err), 0);
        done_pulse();

        // Source address wrap
        snap();
        send(8'h05, 8'h06, 8'h07, 24'hFFFFFE, 11'd3);
        wait_start("w_start", 40);
        chk("w_rd", 32'(rd_cnt - b_rd), 3);
        chk("w_ra0", 32'(rd_log[b_rd % 8192]), 32'hFFFFFE);
        chk("w_ra1", 32'(rd_log[(b_rd + 1) % 8192]), 32'hFFFFFF);
        chk("w_ra2", 32'(rd_log[(b_rd + 2) % 8192]), 32'h000000);
        chk("w_adhi", 32'(tbuf[4]), 32'hFF);
        chk("w_pay0", 32'(tbuf[7]), 32'h5B);
        chk("w_pay2", 32'(tbuf[9]), 32'hA5);
        done_pulse();

        // Request during PAY is dropped
        snap();
        send(8'h31, 8'h32, 8'h33, 24'h000200, 11'd6);
        step(8);
        chk("d_inpay", 32'(tx_buf_wren), 1);
        send(8'h77, 8'h78, 8'h79, 24'h000500, 11'd1);
        wait_start("d_start", 40);
        chk("d_flen", 32'(fl_at_start), 13);
        chk("d_da", 32'(tbuf[0]), 32'h31);
        chk("d_pay5", 32'(tbuf[12]), 32'hA0);
        done_pulse();
        step(20);
        chk("d_one", 32'(start_cnt - b_st), 1);
        chk("d_wr", 32'(wr_cnt - b_wr), 13);

        // Reset during PAY aborts
        snap();
        send(8'h41, 8'h42, 8'h43, 24'h000400, 11'd10);
        step(10);
        reset = 1'b1;
        step(1);
        chk("r_busy", 32'(busy), 0);
        chk("r_outs", 32'({src_rden, tx_buf_wren, tx_start, tx_err, tx_timeout}), 0);
        chk("r_flen", 32'(tx_frame_len), 0);
        reset = 1'b0;
        step(30);
        chk("r_nostart", 32'(start_cnt - b_st), 0);
        chk("r_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
